// File: rtl/writeback_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: FSM state encodings and the
// GPR size codes also understood by the register file.
package writeback_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWb0  = 2'd1,
    StWb1  = 2'd2
  } wb_state_e;

  // Size codes travel untouched to the register file, which does the masking.
  localparam logic [2:0] GprSizeByte  = 3'd1;
  localparam logic [2:0] GprSizeWord  = 3'd2;
  localparam logic [2:0] GprSizeDword = 3'd4;

endpackage

// File: rtl/wb_slot_reg.sv
// Enable-loaded holding register for one GPR write slot {en, number, size, data}.
module wb_slot_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              d_en,
  input  logic [2:0]        d_number,
  input  logic [2:0]        d_size,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_en,
  output logic [2:0]        q_number,
  output logic [2:0]        q_size,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_en     <= 1'b0;
      q_number <= '0;
      q_size   <= '0;
      q_data   <= '0;
    end else if (load) begin
      q_en     <= d_en;
      q_number <= d_number;
      q_size   <= d_size;
      q_data   <= d_data;
    end
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Serialises up to two GPR writes per executed instruction onto one write port,
// issuing segment and MMX writes alongside the first GPR write.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int unsigned REG_W = 32,
  parameter int unsigned SEG_W = 16,
  parameter int unsigned MMX_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             e_valid,
  output logic             e_ready,
  input  logic             e_reg0_en,
  input  logic [2:0]       e_reg0_number,
  input  logic [2:0]       e_reg0_size,
  input  logic [REG_W-1:0] e_reg0_data,
  input  logic             e_reg1_en,
  input  logic [2:0]       e_reg1_number,
  input  logic [2:0]       e_reg1_size,
  input  logic [REG_W-1:0] e_reg1_data,
  input  logic             e_seg_en,
  input  logic [2:0]       e_seg_number,
  input  logic [SEG_W-1:0] e_seg_data,
  input  logic             e_mmx_en,
  input  logic [2:0]       e_mmx_number,
  input  logic [MMX_W-1:0] e_mmx_data,
  output logic             wb_reg_en,
  output logic [2:0]       wb_reg_number,
  output logic [2:0]       wb_reg_size,
  output logic [REG_W-1:0] wb_reg_data,
  output logic             wb_seg_en,
  output logic [2:0]       wb_seg_number,
  output logic [SEG_W-1:0] wb_seg_data,
  output logic             wb_mmx_en,
  output logic [2:0]       wb_mmx_number,
  output logic [MMX_W-1:0] wb_mmx_data,
  output logic             wb_retire
);

  wb_state_e state_q, state_d;
  logic pend1_q;
  logic accept;

  logic             seg_en_q;
  logic [2:0]       seg_number_q;
  logic [SEG_W-1:0] seg_data_q;
  logic             mmx_en_q;
  logic [2:0]       mmx_number_q;
  logic [MMX_W-1:0] mmx_data_q;

  logic             slot0_en, slot1_en;
  logic [2:0]       slot0_number, slot1_number;
  logic [2:0]       slot0_size, slot1_size;
  logic [REG_W-1:0] slot0_data, slot1_data;

  assign e_ready = (state_q == StIdle) | ((state_q == StWb0) & ~pend1_q) | (state_q == StWb1);
  assign accept  = e_valid & e_ready & ~flush;

  // Slot0 takes reg0 when present, otherwise falls back to reg1.
  wb_slot_reg #(.DATA_W(REG_W)) u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .d_en     (e_reg0_en | e_reg1_en),
    .d_number (e_reg0_en ? e_reg0_number : e_reg1_number),
    .d_size   (e_reg0_en ? e_reg0_size : e_reg1_size),
    .d_data   (e_reg0_en ? e_reg0_data : e_reg1_data),
    .q_en     (slot0_en),
    .q_number (slot0_number),
    .q_size   (slot0_size),
    .q_data   (slot0_data)
  );

  wb_slot_reg #(.DATA_W(REG_W)) u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .d_en     (e_reg0_en & e_reg1_en),
    .d_number (e_reg1_number),
    .d_size   (e_reg1_size),
    .d_data   (e_reg1_data),
    .q_en     (slot1_en),
    .q_number (slot1_number),
    .q_size   (slot1_size),
    .q_data   (slot1_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pend1_q      <= 1'b0;
      seg_en_q     <= 1'b0;
      seg_number_q <= '0;
      seg_data_q   <= '0;
      mmx_en_q     <= 1'b0;
      mmx_number_q <= '0;
      mmx_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend1_q      <= e_reg0_en & e_reg1_en;
        seg_en_q     <= e_seg_en;
        seg_number_q <= e_seg_number;
        seg_data_q   <= e_seg_data;
        mmx_en_q     <= e_mmx_en;
        mmx_number_q <= e_mmx_number;
        mmx_data_q   <= e_mmx_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = accept ? StWb0 : StIdle;
      StWb0:   state_d = pend1_q ? StWb1 : (accept ? StWb0 : StIdle);
      StWb1:   state_d = accept ? StWb0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded purely from registered state, never from e_* inputs.
  always_comb begin
    wb_reg_en     = 1'b0;
    wb_reg_number = slot0_number;
    wb_reg_size   = slot0_size;
    wb_reg_data   = slot0_data;
    wb_seg_en     = 1'b0;
    wb_seg_number = seg_number_q;
    wb_seg_data   = seg_data_q;
    wb_mmx_en     = 1'b0;
    wb_mmx_number = mmx_number_q;
    wb_mmx_data   = mmx_data_q;
    wb_retire     = 1'b0;
    unique case (state_q)
      StWb0: begin
        wb_reg_en = slot0_en;
        wb_seg_en = seg_en_q;
        wb_mmx_en = mmx_en_q;
        wb_retire = ~pend1_q;
      end
      StWb1: begin
        wb_reg_en     = slot1_en;
        wb_reg_number = slot1_number;
        wb_reg_size   = slot1_size;
        wb_reg_data   = slot1_data;
        wb_retire     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
